pad_cfg_sequencer: RTL and testbench



---
 rtl/pad_cfg_pkg.sv | 24 ++
 rtl/pad_cfg_divider.sv | 33 +++
 rtl/pad_cfg_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pad_cfg_sequencer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cfg_pkg.sv
// Shared types and constants for the pad configuration sequencer.
// Optional build macro PAD_CFG_AUTOLOAD_EN is consumed by pad_cfg_sequencer.
package pad_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LOAD     = 2'd3
    } pad_cfg_state_e;

    // Bit positions inside one pad configuration word
    localparam int CFG_OE_BIT    = 0;
    localparam int CFG_IE_BIT    = 1;
    localparam int CFG_PU_BIT    = 2;
    localparam int CFG_PD_BIT    = 3;
    localparam int CFG_CS_BIT    = 4;
    localparam int CFG_SL_BIT    = 5;
    localparam int CFG_PDRV0_BIT = 6;
    localparam int CFG_PDRV1_BIT = 7;

    localparam logic [7:0] PAD_CFG_RESET_WORD = 8'h02;

endpackage

// File: rtl/pad_cfg_divider.sv
// CLK_DIV down-counter; tick marks the last core cycle of each serial half period.
module pad_cfg_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    assign tick = (count_reg == 8'd0);

    always_comb begin
        count_next = count_reg - 8'd1;
        if (restart || tick) begin
            count_next = RELOAD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= RELOAD;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/pad_cfg_sequencer.sv
// Per-pad configuration store plus serial shifter for the pad-control chain.
// Define PAD_CFG_AUTOLOAD_EN to shift the reset defaults out automatically after reset.
module pad_cfg_sequencer
    import pad_cfg_pkg::*;
#(
    parameter int NUM_PADS = 38,
    parameter int CLK_DIV  = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_PADS)-1:0] cfg_addr,
    input  logic [7:0]                  cfg_wdata,
    output logic [7:0]                  cfg_rdata,
    output logic                        cfg_wr_err,
    input  logic                        xfer_start,
    output logic                        xfer_busy,
    output logic                        xfer_done,
    output logic                        serial_clock,
    output logic                        serial_load,
    output logic                        serial_data_out
);

    localparam int AW = $clog2(NUM_PADS);
    localparam logic [AW-1:0] LAST_PAD = AW'(NUM_PADS - 1);

    pad_cfg_state_e state_reg, state_next;
    logic [2:0]     bit_idx_reg, bit_idx_next;
    logic [AW-1:0]  pad_idx_reg, pad_idx_next;
    logic [7:0]     store_reg [NUM_PADS];
    logic [NUM_PADS-1:0] wr_en;

    logic addr_ok, wr_accept, start, tick;
    logic [7:0] shift_word;
    logic sclk_reg, sclk_next, sload_reg, sload_next, sdata_reg, sdata_next;
    logic busy_reg, busy_next, done_reg, done_next, wr_err_reg, wr_err_next;

    assign addr_ok   = (int'(cfg_addr) < NUM_PADS);
    assign wr_accept = cfg_we && (state_reg == IDLE) && addr_ok;
    assign cfg_rdata = addr_ok ? store_reg[cfg_addr] : 8'h00;

    generate
        for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_wr_en
            assign wr_en[gi] = wr_accept && (int'(cfg_addr) == gi);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PADS; i++) begin
                store_reg[i] <= PAD_CFG_RESET_WORD;
            end
        end else begin
            for (int i = 0; i < NUM_PADS; i++) begin
                if (wr_en[i]) begin
                    store_reg[i] <= cfg_wdata;
                end
            end
        end
    end

`ifdef PAD_CFG_AUTOLOAD_EN
    // Set by reset, consumed by the first IDLE cycle afterwards
    logic autoload_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            autoload_reg <= 1'b1;
        end else if (state_reg == IDLE) begin
            autoload_reg <= 1'b0;
        end
    end

    assign start = xfer_start || autoload_reg;
`else
    assign start = xfer_start;
`endif

    pad_cfg_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_divider (
        .clock   (clock),
        .reset   (reset),
        .restart (state_reg == IDLE),
        .tick    (tick)
    );

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        pad_idx_next = pad_idx_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = SHIFT_LO;
                    pad_idx_next = LAST_PAD;
                    bit_idx_next = 3'd7;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (bit_idx_reg != 3'd0) begin
                        state_next   = SHIFT_LO;
                        bit_idx_next = bit_idx_reg - 3'd1;
                    end else if (pad_idx_reg != '0) begin
                        state_next   = SHIFT_LO;
                        pad_idx_next = pad_idx_reg - AW'(1);
                        bit_idx_next = 3'd7;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A same-cycle write is bypassed so the transfer shifts the new value
    always_comb begin
        shift_word = store_reg[pad_idx_next];
        if (wr_accept && (cfg_addr == pad_idx_next)) begin
            shift_word = cfg_wdata;
        end
    end

    always_comb begin
        sclk_next   = (state_next == SHIFT_HI);
        sload_next  = (state_next == LOAD);
        busy_next   = (state_next != IDLE);
        done_next   = (state_reg == LOAD) && tick;
        wr_err_next = cfg_we && (state_reg != IDLE);
        sdata_next  = 1'b0;
        if (state_next == SHIFT_LO && state_reg != SHIFT_LO) begin
            sdata_next = shift_word[bit_idx_next];
        end else if (state_next == SHIFT_LO || state_next == SHIFT_HI) begin
            sdata_next = sdata_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_idx_reg <= 3'd0;
            pad_idx_reg <= '0;
            sclk_reg    <= 1'b0;
            sload_reg   <= 1'b0;
            sdata_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            wr_err_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_idx_reg <= bit_idx_next;
            pad_idx_reg <= pad_idx_next;
            sclk_reg    <= sclk_next;
            sload_reg   <= sload_next;
            sdata_reg   <= sdata_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            wr_err_reg  <= wr_err_next;
        end
    end

    assign serial_clock    = sclk_reg;
    assign serial_load     = sload_reg;
    assign serial_data_out = sdata_reg;
    assign xfer_busy       = busy_reg;
    assign xfer_done       = done_reg;
    assign cfg_wr_err      = wr_err_reg;

endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Directed bench for pad_cfg_sequencer: a 2-pad main instance plus a 3-pad instance for range checks.
module tb_pad_cfg_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_addr = 1'b0;
    logic [7:0] cfg_wdata = 8'h00;
    logic [7:0] cfg_rdata;
    logic       cfg_wr_err;
    logic       xfer_start = 1'b0;
    logic       xfer_busy, xfer_done, serial_clock, serial_load, serial_data_out;

    logic       r_cfg_we = 1'b0;
    logic [1:0] r_cfg_addr = 2'd0;
    logic [7:0] r_cfg_wdata = 8'h00;
    logic [7:0] r_cfg_rdata;
    logic       r_cfg_wr_err;
    logic       r_xfer_start = 1'b0;
    logic       r_xfer_busy, r_xfer_done, r_serial_clock, r_serial_load, r_serial_data_out;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int busy_cnt = 0, load_cnt = 0, done_cnt = 0, done_cyc = 0, cap_n = 0;
    logic [15:0] cap_bits = 16'h0000;

    always #5 clock = ~clock;

    pad_cfg_sequencer #(.NUM_PADS(2), .CLK_DIV(2)) dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_wr_err(cfg_wr_err),
        .xfer_start(xfer_start), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .serial_clock(serial_clock), .serial_load(serial_load),
        .serial_data_out(serial_data_out)
    );

    pad_cfg_sequencer #(.NUM_PADS(3), .CLK_DIV(1)) rng (
        .clock(clock), .reset(reset),
        .cfg_we(r_cfg_we), .cfg_addr(r_cfg_addr), .cfg_wdata(r_cfg_wdata),
        .cfg_rdata(r_cfg_rdata), .cfg_wr_err(r_cfg_wr_err),
        .xfer_start(r_xfer_start), .xfer_busy(r_xfer_busy), .xfer_done(r_xfer_done),
        .serial_clock(r_serial_clock), .serial_load(r_serial_load),
        .serial_data_out(r_serial_data_out)
    );

    always @(posedge clock) begin
        cyc++;
        if (xfer_busy) busy_cnt++;
        if (serial_load) load_cnt++;
        if (xfer_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    always @(posedge serial_clock) begin
        cap_bits = {cap_bits[14:0], serial_data_out};
        cap_n++;
    end

    task automatic clear_mon();
        busy_cnt = 0; load_cnt = 0; done_cnt = 0; done_cyc = 0;
        cap_n = 0; cap_bits = 16'h0000;
    endtask

    task automatic write_cfg(input logic a, input logic [7:0] d);
        @(posedge clock); #1;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clock); #1;
        cfg_we = 1'b0;
    endtask

    task automatic write_rng(input logic [1:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        r_cfg_we = 1'b1; r_cfg_addr = a; r_cfg_wdata = d;
        @(posedge clock); #1;
        r_cfg_we = 1'b0;
    endtask

    // Pulses xfer_start (optionally with a write in the same cycle); c0 is the cycle count before the sampling edge
    task automatic start_xfer(input bit with_wr, input logic a, input logic [7:0] d, output int c0);
        @(posedge clock); #1;
        c0 = cyc;
        xfer_start = 1'b1;
        if (with_wr) begin
            cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        end
        @(posedge clock); #1;
        xfer_start = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic wait_done(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clock); #1;
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_vec++;
        if ({serial_clock, serial_load, serial_data_out, cfg_wr_err, xfer_busy, xfer_done} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {serial_clock, serial_load, serial_data_out, cfg_wr_err, xfer_busy, xfer_done});
        end
        reset = 1'b0;
        for (int a = 0; a < 2; a++) begin
            cfg_addr = 1'(a); #1;
            n_vec++;
            if (cfg_rdata !== 8'h02) begin
                n_err++;
                $display("FAIL reset_store pad%0d: got %h expected 02", a, cfg_rdata);
            end
        end
        for (int a = 0; a < 3; a++) begin
            r_cfg_addr = 2'(a); #1;
            n_vec++;
            if (r_cfg_rdata !== 8'h02) begin
                n_err++;
                $display("FAIL reset_store_rng pad%0d: got %h expected 02", a, r_cfg_rdata);
            end
        end
        $display("test_reset: defaults checked");
`ifndef PAD_CFG_AUTOLOAD_EN
        repeat (3) @(negedge clock);
        n_vec++;
        if (xfer_busy !== 1'b0 || serial_clock !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: busy=%b sclk=%b expected 0 0", xfer_busy, serial_clock);
        end
`endif
    endtask

`ifdef PAD_CFG_AUTOLOAD_EN
    task automatic test_autoload();
        int c0;
        bit to;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        c0 = cyc;
        clear_mon();
        @(negedge clock);
        n_vec++;
        if (xfer_busy !== 1'b0) begin
            n_err++;
            $display("FAIL autoload_busy_early: got %b expected 0", xfer_busy);
        end
        @(negedge clock);
        n_vec++;
        if (xfer_busy !== 1'b1) begin
            n_err++;
            $display("FAIL autoload_busy_rise: got %b expected 1", xfer_busy);
        end
        wait_done(to);
        n_vec++;
        if (to || cap_bits !== 16'h0202 || cap_n != 16) begin
            n_err++;
            $display("FAIL autoload_stream: got %h (%0d bits, timeout=%0d) expected 0202 (16 bits)", cap_bits, cap_n, to);
        end
        n_vec++;
        if (done_cnt != 1 || done_cyc - c0 != 68 || busy_cnt != 66) begin
            n_err++;
            $display("FAIL autoload_timing: done_cnt=%0d done_at=%0d busy=%0d expected 1 68 66",
                     done_cnt, done_cyc - c0, busy_cnt);
        end
        $display("test_autoload: stream=%h done_at=%0d", cap_bits, done_cyc - c0);
    endtask
`endif

    task automatic test_full_transfer();
        int c0;
        bit to;
        write_cfg(1'b0, 8'hA5);
        write_cfg(1'b1, 8'h3C);
        cfg_addr = 1'b0; #1;
        n_vec++;
        if (cfg_rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL readback pad0: got %h expected a5", cfg_rdata);
        end
        cfg_addr = 1'b1; #1;
        n_vec++;
        if (cfg_rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL readback pad1: got %h expected 3c", cfg_rdata);
        end
        clear_mon();
        start_xfer(1'b0, 1'b0, 8'h00, c0);
        n_vec++;
        if (xfer_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b expected 1", xfer_busy);
        end
        wait_done(to);
        n_vec++;
        if (to || cap_bits !== 16'h3CA5 || cap_n != 16) begin
            n_err++;
            $display("FAIL full_stream: got %h (%0d bits, timeout=%0d) expected 3ca5 (16 bits)", cap_bits, cap_n, to);
        end
        n_vec++;
        if (busy_cnt != 66 || load_cnt != 2) begin
            n_err++;
            $display("FAIL full_busy_load: busy=%0d load=%0d expected 66 2", busy_cnt, load_cnt);
        end
        n_vec++;
        if (done_cnt != 1 || done_cyc - c0 != 68) begin
            n_err++;
            $display("FAIL full_done: count=%0d at=%0d expected 1 68", done_cnt, done_cyc - c0);
        end
        $display("test_full_transfer: stream=%h busy=%0d load=%0d done=%0d", cap_bits, busy_cnt, load_cnt, done_cnt);
    endtask

    task automatic test_busy_block();
        int c0;
        bit to;
        clear_mon();
        start_xfer(1'b0, 1'b0, 8'h00, c0);
        repeat (9) @(posedge clock);
        #1;
        n_vec++;
        if (cfg_wr_err !== 1'b0) begin
            n_err++;
            $display("FAIL wr_err_idle: got %b expected 0", cfg_wr_err);
        end
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = 8'hFF;
        @(posedge clock); #1;
        cfg_we = 1'b0;
        n_vec++;
        if (cfg_wr_err !== 1'b1) begin
            n_err++;
            $display("FAIL wr_err_pulse: got %b expected 1", cfg_wr_err);
        end
        @(posedge clock); #1;
        n_vec++;
        if (cfg_wr_err !== 1'b0) begin
            n_err++;
            $display("FAIL wr_err_width: got %b expected 0", cfg_wr_err);
        end
        wait_done(to);
        cfg_addr = 1'b0; #1;
        n_vec++;
        if (cfg_rdata !== 8'hA5) begin
            n_err++;
            $display("FAIL busy_write_dropped: got %h expected a5", cfg_rdata);
        end
        n_vec++;
        if (to || cap_bits !== 16'h3CA5) begin
            n_err++;
            $display("FAIL busy_stream: got %h (timeout=%0d) expected 3ca5", cap_bits, to);
        end
        $display("test_busy_block: stream=%h pad0=%h", cap_bits, cfg_rdata);
    endtask

    task automatic test_range();
        write_rng(2'd3, 8'h55);
        n_vec++;
        if (r_cfg_wr_err !== 1'b0) begin
            n_err++;
            $display("FAIL range_wr_err: got %b expected 0", r_cfg_wr_err);
        end
        r_cfg_addr = 2'd3; #1;
        n_vec++;
        if (r_cfg_rdata !== 8'h00) begin
            n_err++;
            $display("FAIL range_read: got %h expected 00", r_cfg_rdata);
        end
        for (int a = 0; a < 3; a++) begin
            r_cfg_addr = 2'(a); #1;
            n_vec++;
            if (r_cfg_rdata !== 8'h02) begin
                n_err++;
                $display("FAIL range_untouched pad%0d: got %h expected 02", a, r_cfg_rdata);
            end
        end
        write_rng(2'd2, 8'h77);
        r_cfg_addr = 2'd2; #1;
        n_vec++;
        if (r_cfg_rdata !== 8'h77) begin
            n_err++;
            $display("FAIL range_last_pad: got %h expected 77", r_cfg_rdata);
        end
        $display("test_range: out-of-range write ignored, pad2=%h", r_cfg_rdata);
    endtask

    task automatic test_collision();
        int c0;
        bit to;
        clear_mon();
        start_xfer(1'b1, 1'b1, 8'h81, c0);
        wait_done(to);
        n_vec++;
        if (to || cap_bits !== 16'h81A5) begin
            n_err++;
            $display("FAIL collision_stream: got %h (timeout=%0d) expected 81a5", cap_bits, to);
        end
        cfg_addr = 1'b1; #1;
        n_vec++;
        if (cfg_rdata !== 8'h81) begin
            n_err++;
            $display("FAIL collision_store: got %h expected 81", cfg_rdata);
        end
        $display("test_collision: stream=%h pad1=%h", cap_bits, cfg_rdata);
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_mon();
        start_xfer(1'b0, 1'b0, 8'h00, c0);
        repeat (19) @(posedge clock);
        #2;
        n_vec++;
        if (xfer_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy_before: got %b expected 1", xfer_busy);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({serial_clock, serial_load, serial_data_out, xfer_busy} !== 4'b0) begin
            n_err++;
            $display("FAIL mid_async_clear: got %b expected 0000",
                     {serial_clock, serial_load, serial_data_out, xfer_busy});
        end
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        n_vec++;
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL mid_no_done: got %0d pulses expected 0", done_cnt);
        end
        for (int a = 0; a < 2; a++) begin
            cfg_addr = 1'(a); #1;
            n_vec++;
            if (cfg_rdata !== 8'h02) begin
                n_err++;
                $display("FAIL mid_store pad%0d: got %h expected 02", a, cfg_rdata);
            end
        end
        $display("test_reset_mid: outputs cleared, done pulses=%0d", done_cnt);
    endtask

    initial begin
        test_reset();
`ifdef PAD_CFG_AUTOLOAD_EN
        test_autoload();
`endif
        test_full_transfer();
        test_busy_block();
        test_range();
        test_collision();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
